// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - RV32I instruction-class types, opcodes and NOP shared by the pipeline control
package rv32i_pkg;

    typedef enum logic [2:0] {
        R_TYPE = 3'd0,
        I_TYPE = 3'd1,
        S_TYPE = 3'd2,
        B_TYPE = 3'd3,
        U_TYPE = 3'd4,
        J_TYPE = 3'd5
    } instr_type_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Stores and branches have no destination register.
    function automatic logic writes_rd(input instr_type_t t);
        return !((t == S_TYPE) || (t == B_TYPE));
    endfunction

endpackage

// File: rtl/rv32i_type_decode.sv
// rtl/rv32i_type_decode.sv - combinational opcode to instruction-class and destination decode
module rv32i_type_decode
    import rv32i_pkg::*;
#(
    parameter int REG_WIDTH = 5
) (
    input  logic [6:0]           opcode,
    input  logic [4:0]           rd_field,
    output instr_type_t          itype,
    output logic [REG_WIDTH-1:0] rd
);

    always_comb begin
        itype = S_TYPE;
        case (opcode)
            OP_R:                       itype = R_TYPE;
            OP_IMM, OP_LOAD, OP_JALR:   itype = I_TYPE;
            OP_STORE:                   itype = S_TYPE;
            OP_BRANCH:                  itype = B_TYPE;
            OP_LUI, OP_AUIPC:           itype = U_TYPE;
            OP_JAL:                     itype = J_TYPE;
            default:                    itype = S_TYPE;
        endcase
    end

    // Unknown opcodes fall into S_TYPE so they never write a register.
    always_comb begin
        rd = '0;
        if (writes_rd(itype)) begin
            rd = REG_WIDTH'(rd_field);
        end
    end

endmodule

// File: rtl/pipe_stage_ctrl.sv
// rtl/pipe_stage_ctrl.sv - PC and F/D, D/E, E/M pipeline-register control with stall, flush and redirect
module pipe_stage_ctrl
    import rv32i_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter int              REG_WIDTH = 5,
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [XLEN-1:0]      instrF,
    input  logic                 stallD,
    input  logic                 flushE,
    input  logic                 branch_takenE,
    input  logic [XLEN-1:0]      branch_targetE,
    output logic [XLEN-1:0]      pcF,
    output logic [XLEN-1:0]      instrD,
    output logic [XLEN-1:0]      pcD,
    output logic                 validD,
    output logic [REG_WIDTH-1:0] Rs1D,
    output logic [REG_WIDTH-1:0] Rs2D,
    output logic [REG_WIDTH-1:0] RdE,
    output logic [REG_WIDTH-1:0] RdM,
    output instr_type_t          regwriteE,
    output logic                 validE,
    output logic                 validM
);

    localparam logic [XLEN-1:0] NOP_X  = XLEN'(NOP_INSTR);
    localparam logic [XLEN-1:0] PC_INC = XLEN'(4);

    instr_type_t          typeD;
    logic [REG_WIDTH-1:0] RdD;

    rv32i_type_decode #(
        .REG_WIDTH (REG_WIDTH)
    ) u_decode (
        .opcode   (instrD[6:0]),
        .rd_field (instrD[11:7]),
        .itype    (typeD),
        .rd       (RdD)
    );

    assign Rs1D = REG_WIDTH'(instrD[19:15]);
    assign Rs2D = REG_WIDTH'(instrD[24:20]);

    // Redirect beats stall; the adder wraps naturally at 2^XLEN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcF <= RESET_PC;
        end else if (branch_takenE) begin
            pcF <= branch_targetE;
        end else if (!stallD) begin
            pcF <= pcF + PC_INC;
        end
    end

    // F/D: a redirect squashes the wrong-path word but keeps pcD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instrD <= NOP_X;
            pcD    <= RESET_PC;
            validD <= 1'b0;
        end else if (branch_takenE) begin
            instrD <= NOP_X;
            validD <= 1'b0;
        end else if (!stallD) begin
            instrD <= instrF;
            pcD    <= pcF;
            validD <= 1'b1;
        end
    end

    // D/E: a stall without flush lets D/E advance; the hazard unit
    // pairs stallD with flushE when a bubble is needed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regwriteE <= S_TYPE;
            RdE       <= '0;
            validE    <= 1'b0;
        end else if (branch_takenE || flushE) begin
            regwriteE <= S_TYPE;
            RdE       <= '0;
            validE    <= 1'b0;
        end else begin
            regwriteE <= typeD;
            RdE       <= RdD;
            validE    <= validD;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            RdM    <= '0;
            validM <= 1'b0;
        end else begin
            RdM    <= RdE;
            validM <= validE;
        end
    end

endmodule

// File: tb/tb_pipe_stage_ctrl.sv
// tb/tb_pipe_stage_ctrl.sv - directed and randomized checks of pipe_stage_ctrl against a stage-record model
module tb_pipe_stage_ctrl;
    import rv32i_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instrF = 32'h0;
    logic        stallD = 1'b0;
    logic        flushE = 1'b0;
    logic        branch_takenE = 1'b0;
    logic [31:0] branch_targetE = 32'h0;
    logic [31:0] pcF, instrD, pcD;
    logic        validD, validE, validM;
    logic [4:0]  Rs1D, Rs2D, RdE, RdM;
    instr_type_t regwriteE;

    int tests = 0;
    int fails = 0;

    pipe_stage_ctrl #(.XLEN(32), .REG_WIDTH(5), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .instrF(instrF), .stallD(stallD), .flushE(flushE),
        .branch_takenE(branch_takenE), .branch_targetE(branch_targetE),
        .pcF(pcF), .instrD(instrD), .pcD(pcD), .validD(validD),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdE(RdE), .RdM(RdM),
        .regwriteE(regwriteE), .validE(validE), .validM(validM)
    );

    always #5 clk = ~clk;

    // Reference: each stage holds a record of what instruction occupies it.
    logic [31:0] m_pc;
    logic [31:0] d_instr, d_pc;
    logic        d_valid;
    instr_type_t e_type;
    logic [4:0]  e_rd;
    logic        e_valid;
    logic [4:0]  m_rd;
    logic        m_valid;

    function automatic instr_type_t ref_type(input logic [31:0] ins);
        logic [6:0] op;
        op = ins[6:0];
        if (op == 7'h33) return R_TYPE;
        if (op == 7'h13 || op == 7'h03 || op == 7'h67) return I_TYPE;
        if (op == 7'h63) return B_TYPE;
        if (op == 7'h37 || op == 7'h17) return U_TYPE;
        if (op == 7'h6F) return J_TYPE;
        return S_TYPE;
    endfunction

    function automatic logic [4:0] ref_rd(input logic [31:0] ins);
        instr_type_t t;
        t = ref_type(ins);
        return (t == S_TYPE || t == B_TYPE) ? 5'd0 : ins[11:7];
    endfunction

    task automatic model_reset();
        m_pc = 32'h0; d_instr = 32'h13; d_pc = 32'h0; d_valid = 1'b0;
        e_type = S_TYPE; e_rd = 5'd0; e_valid = 1'b0; m_rd = 5'd0; m_valid = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        chk("pcF", pcF, m_pc);
        chk("instrD", instrD, d_instr);
        chk("pcD", pcD, d_pc);
        chk("validD", 32'(validD), 32'(d_valid));
        chk("Rs1D", 32'(Rs1D), 32'(d_instr[19:15]));
        chk("Rs2D", 32'(Rs2D), 32'(d_instr[24:20]));
        chk("regwriteE", 32'(regwriteE), 32'(e_type));
        chk("RdE", 32'(RdE), 32'(e_rd));
        chk("validE", 32'(validE), 32'(e_valid));
        chk("RdM", 32'(RdM), 32'(m_rd));
        chk("validM", 32'(validM), 32'(m_valid));
    endtask

    task automatic step(input logic br, input logic [31:0] tgt, input logic st,
                        input logic fl, input logic [31:0] ins);
        branch_takenE = br; branch_targetE = tgt; stallD = st; flushE = fl; instrF = ins;
        @(posedge clk);
        m_rd = e_rd; m_valid = e_valid;
        if (br || fl) begin
            e_type = S_TYPE; e_rd = 5'd0; e_valid = 1'b0;
        end else begin
            e_type = ref_type(d_instr); e_rd = ref_rd(d_instr); e_valid = d_valid;
        end
        if (br) begin
            d_instr = 32'h13; d_valid = 1'b0;
        end else if (!st) begin
            d_instr = ins; d_pc = m_pc; d_valid = 1'b1;
        end
        if (br) m_pc = tgt;
        else if (!st) m_pc = m_pc + 32'd4;
        #1;
        check_all();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0] ops [10];
        ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h7F};
        return {$urandom} & 32'hFFFF_FF80 | 32'(ops[$urandom_range(0, 9)]);
    endfunction

    logic [31:0] held_pc;

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst = 1'b0;

        // Straight-line fetch and 3-cycle D->M latency.
        for (int i = 1; i <= 4; i++) begin
            step(0, 0, 0, 0, rand_instr());
            chk("pc_seq", pcF, 32'(i * 4));
            if (i == 3) chk("validM_c3", 32'(validM), 32'd1);
        end

        // Load-use stall with bubble into E.
        step(0, 0, 0, 0, 32'h0000_02B3);
        held_pc = pcF;
        for (int i = 0; i < 2; i++) begin
            step(0, 0, 1, 1, rand_instr());
            chk("lu_instrD", instrD, 32'h0000_02B3);
            chk("lu_pcF", pcF, held_pc);
            chk("lu_validE", 32'(validE), 32'd0);
            chk("lu_regwriteE", 32'(regwriteE), 32'(S_TYPE));
            chk("lu_RdE", 32'(RdE), 32'd0);
        end
        step(0, 0, 0, 0, rand_instr());
        chk("lu_resume_RdE", 32'(RdE), 32'd5);
        chk("lu_resume_type", 32'(regwriteE), 32'(R_TYPE));

        // Branch wins over stall.
        step(1, 32'h0000_0100, 1, 0, rand_instr());
        chk("br_pcF", pcF, 32'h0000_0100);
        chk("br_validD", 32'(validD), 32'd0);
        chk("br_validE", 32'(validE), 32'd0);

        // Store and unknown opcode never name a destination.
        step(0, 0, 0, 0, 32'h0051_2023);
        step(0, 0, 0, 0, 32'h0000_0FFF);
        chk("sw_type", 32'(regwriteE), 32'(S_TYPE));
        chk("sw_RdE", 32'(RdE), 32'd0);
        step(0, 0, 0, 0, rand_instr());
        chk("unk_type", 32'(regwriteE), 32'(S_TYPE));
        chk("unk_RdE", 32'(RdE), 32'd0);

        // PC wrap.
        step(1, 32'hFFFF_FFFC, 0, 0, rand_instr());
        step(0, 0, 0, 0, rand_instr());
        chk("wrap_pcF", pcF, 32'h0000_0000);

        // Asynchronous reset asserted mid-stall, between edges.
        step(0, 0, 1, 0, rand_instr());
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        check_all();
        rst = 1'b0;
        step(0, 0, 0, 0, rand_instr());
        chk("rst_resume_pcD", pcD, 32'h0);

        for (int i = 0; i < 300; i++) begin
            step($urandom_range(0, 7) == 0, {$urandom} & 32'hFFFF_FFFC,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0, rand_instr());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
